// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned 4x4 hex keypad with frame debounce, one-cycle key events
// and an 8-nibble entry history. Optional auto-repeat when KEYPAD_AUTOREPEAT_EN is defined.
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV        = 256,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [3:0]      ROW,
    input  logic [3:0]      COL,
    output logic            key_valid,
    output logic [3:0]      key_code,
    output logic            key_held,
    output logic [7:0][3:0] nibbles_out
);
    localparam int          DIV_W   = $clog2(SCAN_DIV);
    localparam int          CNT_W   = DIV_W + 2;
    localparam logic [3:0]  DEB_MAX = 4'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 4 || (1 << DIV_W) != SCAN_DIV || DEBOUNCE_FRAMES < 1 ||
        DEBOUNCE_FRAMES > 15 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
        $error("keypad_scanner: illegal parameter combination");
    end

    logic [CNT_W-1:0] scan_cnt_q;
    logic [3:0]       row_q;
    logic [3:0]       col_meta_q, col_sync_q;
    logic [15:0]      snap_q, snap_d;
    logic [15:0]      prev_q;
    logic [3:0]       stable_cnt_q, stable_cnt_d;
    logic [15:0]      deb_q;
    logic             held_q;
    logic             valid_q;
    logic [3:0]       code_q;
    logic [7:0][3:0]  hist_q;

    logic [1:0]       row_idx;
    logic             slot_end, frame_end, load, onehot, press_ev, rpt_ev, fire;
    logic [3:0]       idx, fire_code;

    assign row_idx   = scan_cnt_q[CNT_W-1 -: 2];
    assign slot_end  = &scan_cnt_q[DIV_W-1:0];
    assign frame_end = slot_end && (row_idx == 2'd3);

    // snap_d already holds the row being sampled this cycle, so frame_end compares a full frame
    always_comb begin
        snap_d = snap_q;
        if (slot_end) begin
            snap_d[{row_idx, 2'b00} +: 4] = ~col_sync_q;
        end
    end

    always_comb begin
        stable_cnt_d = stable_cnt_q;
        load         = 1'b0;
        if (frame_end) begin
            if (snap_d == prev_q) begin
                if (stable_cnt_q != DEB_MAX) begin
                    stable_cnt_d = stable_cnt_q + 4'd1;
                end
            end else begin
                stable_cnt_d = 4'd0;
            end
            load = (stable_cnt_d == DEB_MAX) && (stable_cnt_q != DEB_MAX);
        end
    end

    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign onehot   = (snap_d != 16'd0) && ((snap_d & (snap_d - 16'd1)) == 16'd0);
    assign press_ev = load && (deb_q == 16'd0) && onehot;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             armed_q, armed_d;

    // Only a press that produced an event arms repeat; a multi-to-single reduction never does.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        armed_d   = armed_q;
        rpt_ev    = 1'b0;
        if (load && (snap_d != deb_q)) begin
            armed_d   = press_ev;
            rpt_cnt_d = '0;
        end else if (frame_end && armed_q) begin
            if ((32'(rpt_cnt_q) + 32'd1) == 32'(REPEAT_DELAY)) begin
                rpt_ev    = 1'b1;
                rpt_cnt_d = RPT_W'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            armed_q   <= armed_d;
        end
    end
`else
    assign rpt_ev = 1'b0;
`endif

    assign fire      = press_ev | rpt_ev;
    assign fire_code = press_ev ? idx : code_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q   <= '0;
            row_q        <= 4'hF;
            col_meta_q   <= 4'h0;
            col_sync_q   <= 4'h0;
            snap_q       <= 16'd0;
            prev_q       <= 16'd0;
            stable_cnt_q <= 4'd0;
            deb_q        <= 16'd0;
            held_q       <= 1'b0;
            valid_q      <= 1'b0;
            code_q       <= 4'd0;
            hist_q       <= '0;
        end else begin
            scan_cnt_q   <= scan_cnt_q + 1'b1;
            row_q        <= ~(4'b0001 << row_idx);
            col_meta_q   <= COL;
            col_sync_q   <= col_meta_q;
            snap_q       <= snap_d;
            stable_cnt_q <= stable_cnt_d;
            valid_q      <= fire;
            if (frame_end) begin
                prev_q <= snap_d;
            end
            if (load) begin
                deb_q  <= snap_d;
                held_q <= (snap_d != 16'd0);
            end
            if (fire) begin
                code_q <= fire_code;
                hist_q <= {hist_q[6:0], fire_code};
            end
        end
    end

    assign ROW         = row_q;
    assign key_valid   = valid_q;
    assign key_code    = code_q;
    assign key_held    = held_q;
    assign nibbles_out = hist_q;

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the seven-segment display driver: scans a 4x4 hex keypad matrix and debounces it.
- Emits one-cycle key events carrying a 4-bit code.
- Maintains an 8-nibble entry history, shaped as an 8x4 array, so it can feed the display driver's nibble input directly.
- Sits in io_ctrl between the board keypad pins and the game/UI logic.

Parameters:
- SCAN_DIV, 256, clock cycles each row is driven per scan slot; power of 2, >= 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full-matrix frames required before the debounced state updates; range 1..15.
- REPEAT_DELAY, 64, frames a single key must be held before the first auto-repeat event; used only with the optional feature.
- REPEAT_RATE, 16, frames between subsequent auto-repeat events; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ROW  out  4  keypad row drives, active low; exactly one bit is low while scanning.
- COL  in  4  keypad column sense, active low (external pull-ups); asynchronous to clk.
- key_valid  out  1  one-cycle pulse when a key event occurs.
- key_code  out  4  code of the last event: code = 4*row + col; held between events.
- key_held  out  1  high while the debounced matrix has any key pressed.
- nibbles_out  out  8x4  entry history; [0] is the newest code, [7] the oldest.

Behaviour:
- Reset (async assert, reset_n=0): all registers clear immediately, with no clock edge needed.
  - ROW=4'hF, key_valid=0, key_code=0, key_held=0, nibbles_out=all 0.
  - Scan counter, synchronizer, snapshot, debounced state and stable counter all 0.
- Reset release: first rising edge after release drives ROW=4'hE (row 0). Reset mid-scan aborts the frame; scanning restarts at row 0.
- COL synchronizer: 2 flops, and the raw COL input is used nowhere else.
- Scan counter: width log2(SCAN_DIV)+2, free-running, wraps.
  - Top 2 bits = row index r; ROW = ~(1<<r), registered.
  - Frame = 4*SCAN_DIV cycles.
- Sampling:
  - On the last cycle of each row slot (low bits all 1), the inverted synchronized COL is captured into snapshot bits [4r+3:4r].
  - Sampling this late gives at least SCAN_DIV-3 cycles for settling and synchronization.
- Frame end (the cycle row 3 is sampled; snapshot includes that row's bits). Compare snapshot with the previous frame's snapshot:
  - Equal: stable_cnt increments, saturating at DEBOUNCE_FRAMES.
  - Different: stable_cnt resets to 0.
  - When stable_cnt becomes equal to DEBOUNCE_FRAMES (transition only), debounced is loaded with snapshot.
- Event rule: key_valid=1 for exactly one cycle, on the same edge that debounced is loaded, if:
  - the previous debounced value was 0, and
  - the new value has exactly one bit set.
- On an event, on that same edge:
  - key_code = index of the set bit.
  - nibbles_out shifts: [7..1] take the old [6..0], and [0] takes the new code.
- Multiple keys pressed: no event. key_held=1. A later reduction to a single key does not generate an event; all keys must be released first (debounced == 0).
- key_held = (debounced != 0), registered, updating on the same edge as debounced.
- Glitches shorter than DEBOUNCE_FRAMES frames never change debounced.
- Event latency from a clean press: between DEBOUNCE_FRAMES and DEBOUNCE_FRAMES+1 frames.
- History wraps: the ninth event pushes the first code out of [7].

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: while debounced is stable with exactly one key set:
  - a frame counter counts frames since the event;
  - after REPEAT_DELAY frames, key_valid pulses again with the same code and the history shifts;
  - further repeats follow every REPEAT_RATE frames;
  - the counter clears on any change of debounced.
- Undefined: no repeat logic; REPEAT_DELAY and REPEAT_RATE are ignored; one event per press.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2; frame = 16 cycles):
- Reset: hold reset_n=0 mid-frame.
  - Required: ROW=4'hF and all outputs 0 with no clock edge.
  - After release: ROW sequence E,D,B,7 repeating, each row held 4 cycles.
- Single press of row 2, col 1 (COL=4'hD only while ROW=4'hB), held 5 frames.
  - Required: exactly one key_valid pulse, 2-3 frames after the press.
  - Required: key_code=9, nibbles_out[0]=9, key_held=1.
  - After release: key_held drops about 2 frames later with no pulse.
- Bounce: key toggles every frame for 6 frames, then stays released.
  - Required: no key_valid, key_held stays 0.
- Two keys, row 0 col 0 and row 3 col 3, pressed together; then row 3 col 3 released.
  - Required: key_held=1 and no key_valid throughout.
  - Release both, then press row 3 col 3 alone: one pulse with code=15.
- History: nine single-key presses with codes 1..9.
  - Required: nibbles_out[0]=9 through nibbles_out[7]=2; code 1 is discarded.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, row 1 col 0 held 12 frames after its event.
  - Required: pulses with code 4 at +0, +4, +6, +8, +10 and +12 frames.
